// File: rtl/lane_delay_move_sequencer.sv
// lane_delay_move_sequencer
// Shares one DQS delay-line adjust interface between NREQ training requesters.
// Each granted operation is wrapped in an HS_IO_CLK_PAUSE window:
// SETUP -> optional LOAD -> MOVE/GAP repeated -> HOLD -> FIN.
// Ports:
//   CLK, RESET_N          fabric clock, async active-low reset
//   REQ/REQ_LOAD/REQ_SEL/REQ_DIR/REQ_TAPS  per-requester operation request
//   GNT, DONE, BUSY       one-hot grant, one-cycle completion, busy status
//   ERR_OOR, TAPS_DONE    result of the last completed operation
//   RX_OOR, TX_OOR        delay-line out-of-range from the lane controller
//   DELAY_LINE_*, HS_IO_CLK_PAUSE  lane controller delay-line controls
module lane_delay_move_sequencer #(
  parameter int unsigned NREQ      = 2,
  parameter int unsigned CNT_W     = 8,
  parameter int unsigned SETUP_CYC = 4,
  parameter int unsigned GAP_CYC   = 2,
  parameter int unsigned HOLD_CYC  = 4
) (
  input  logic                  CLK,
  input  logic                  RESET_N,
  input  logic [NREQ-1:0]       REQ,
  input  logic [NREQ-1:0]       REQ_LOAD,
  input  logic [NREQ-1:0]       REQ_SEL,
  input  logic [NREQ-1:0]       REQ_DIR,
  input  logic [NREQ*CNT_W-1:0] REQ_TAPS,
  output logic [NREQ-1:0]       GNT,
  output logic [NREQ-1:0]       DONE,
  output logic                  ERR_OOR,
  output logic [CNT_W-1:0]      TAPS_DONE,
  output logic                  BUSY,
  input  logic                  RX_OOR,
  input  logic                  TX_OOR,
  output logic                  DELAY_LINE_SEL,
  output logic                  DELAY_LINE_LOAD,
  output logic                  DELAY_LINE_DIRECTION,
  output logic                  DELAY_LINE_MOVE,
  output logic                  HS_IO_CLK_PAUSE
);

  localparam int unsigned PTR_W   = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned MAX_SG  = (SETUP_CYC > GAP_CYC) ? SETUP_CYC : GAP_CYC;
  localparam int unsigned MAX_CYC = (MAX_SG > HOLD_CYC) ? MAX_SG : HOLD_CYC;
  localparam int unsigned TMR_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_SETUP = 3'd1;
  localparam logic [2:0] ST_LOAD  = 3'd2;
  localparam logic [2:0] ST_MOVE  = 3'd3;
  localparam logic [2:0] ST_GAP   = 3'd4;
  localparam logic [2:0] ST_HOLD  = 3'd5;
  localparam logic [2:0] ST_FIN   = 3'd6;

  logic [2:0]       state_q, state_d;
  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic [PTR_W-1:0] own_q, own_d;
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic             cap_load_q, cap_load_d;
  logic             cap_sel_q, cap_sel_d;
  logic             cap_dir_q, cap_dir_d;
  logic [CNT_W-1:0] cap_taps_q, cap_taps_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;

  logic [NREQ-1:0]  gnt_d, done_d;
  logic             busy_d, pause_d, sel_d, dir_d, load_d, move_d, err_out_d;
  logic [CNT_W-1:0] taps_out_d;

  logic             win_found;
  logic [PTR_W-1:0] win_idx;
  logic [CNT_W-1:0] win_taps;
  logic             oor_c;
  int               arb_idx;

  // Round-robin arbitration starting at the pointer
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    arb_idx   = 0;
    for (int k = 0; k < int'(NREQ); k++) begin
      arb_idx = (int'(ptr_q) + k) % int'(NREQ);
      if (!win_found && REQ[arb_idx]) begin
        win_found = 1'b1;
        win_idx   = PTR_W'(arb_idx);
      end
    end
    win_taps = REQ_TAPS[int'(win_idx)*int'(CNT_W) +: CNT_W];
  end

  // Next-state and next-output logic
  always_comb begin
    state_d    = state_q;
    tmr_d      = tmr_q;
    own_d      = own_q;
    ptr_d      = ptr_q;
    cap_load_d = cap_load_q;
    cap_sel_d  = cap_sel_q;
    cap_dir_d  = cap_dir_q;
    cap_taps_d = cap_taps_q;
    cnt_d      = cnt_q;
    err_d      = err_q;
    err_out_d  = ERR_OOR;
    taps_out_d = TAPS_DONE;
    oor_c      = cap_sel_q ? TX_OOR : RX_OOR;

    case (state_q)
      ST_IDLE: begin
        if (win_found) begin
          own_d      = win_idx;
          cap_load_d = REQ_LOAD[win_idx];
          cap_sel_d  = REQ_SEL[win_idx];
          cap_dir_d  = REQ_DIR[win_idx];
          cap_taps_d = win_taps;
          cnt_d      = '0;
          err_d      = 1'b0;
          // Empty operation: one unpaused grant cycle, then FIN
          if (win_taps == '0 && !REQ_LOAD[win_idx]) begin
            state_d = ST_HOLD;
            tmr_d   = '0;
          end else begin
            state_d = ST_SETUP;
            tmr_d   = TMR_W'(SETUP_CYC - 1);
          end
        end
      end
      ST_SETUP: begin
        if (tmr_q == '0) begin
          if (cap_load_q) begin
            state_d = ST_LOAD;
          end else if (cap_taps_q != '0) begin
            state_d = ST_MOVE;
          end else begin
            state_d = ST_HOLD;
            tmr_d   = TMR_W'(HOLD_CYC - 1);
          end
        end else begin
          tmr_d = tmr_q - TMR_W'(1);
        end
      end
      ST_LOAD: begin
        state_d = ST_GAP;
        tmr_d   = TMR_W'(GAP_CYC - 1);
      end
      ST_MOVE: begin
        cnt_d   = cnt_q + CNT_W'(1);
        state_d = ST_GAP;
        tmr_d   = TMR_W'(GAP_CYC - 1);
      end
      ST_GAP: begin
        // Out-of-range only counts on the last settle cycle
        if (tmr_q == '0) begin
          if (oor_c) begin
            err_d   = 1'b1;
            state_d = ST_HOLD;
            tmr_d   = TMR_W'(HOLD_CYC - 1);
          end else if (cnt_q < cap_taps_q) begin
            state_d = ST_MOVE;
          end else begin
            state_d = ST_HOLD;
            tmr_d   = TMR_W'(HOLD_CYC - 1);
          end
        end else begin
          tmr_d = tmr_q - TMR_W'(1);
        end
      end
      ST_HOLD: begin
        if (tmr_q == '0) begin
          state_d = ST_FIN;
        end else begin
          tmr_d = tmr_q - TMR_W'(1);
        end
      end
      ST_FIN: begin
        state_d = ST_IDLE;
        ptr_d   = PTR_W'((int'(own_q) + 1) % int'(NREQ));
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Result status becomes visible together with DONE
    if (state_d == ST_FIN && state_q != ST_FIN) begin
      err_out_d  = err_d;
      taps_out_d = cnt_d;
    end

    busy_d = (state_d != ST_IDLE);
    gnt_d  = '0;
    done_d = '0;
    if (busy_d) begin
      gnt_d[own_d] = 1'b1;
    end
    if (state_d == ST_FIN) begin
      done_d[own_d] = 1'b1;
    end
    sel_d   = busy_d & cap_sel_d;
    dir_d   = busy_d & cap_dir_d;
    pause_d = (state_d == ST_SETUP) || (state_d == ST_LOAD) ||
              (state_d == ST_MOVE)  || (state_d == ST_GAP);
    load_d  = (state_d == ST_LOAD);
    move_d  = (state_d == ST_MOVE);
  end

  // State and registered outputs
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q              <= ST_IDLE;
      tmr_q                <= '0;
      own_q                <= '0;
      ptr_q                <= '0;
      cap_load_q           <= 1'b0;
      cap_sel_q            <= 1'b0;
      cap_dir_q            <= 1'b0;
      cap_taps_q           <= '0;
      cnt_q                <= '0;
      err_q                <= 1'b0;
      GNT                  <= '0;
      DONE                 <= '0;
      BUSY                 <= 1'b0;
      ERR_OOR              <= 1'b0;
      TAPS_DONE            <= '0;
      DELAY_LINE_SEL       <= 1'b0;
      DELAY_LINE_DIRECTION <= 1'b0;
      DELAY_LINE_LOAD      <= 1'b0;
      DELAY_LINE_MOVE      <= 1'b0;
      HS_IO_CLK_PAUSE      <= 1'b0;
    end else begin
      state_q              <= state_d;
      tmr_q                <= tmr_d;
      own_q                <= own_d;
      ptr_q                <= ptr_d;
      cap_load_q           <= cap_load_d;
      cap_sel_q            <= cap_sel_d;
      cap_dir_q            <= cap_dir_d;
      cap_taps_q           <= cap_taps_d;
      cnt_q                <= cnt_d;
      err_q                <= err_d;
      GNT                  <= gnt_d;
      DONE                 <= done_d;
      BUSY                 <= busy_d;
      ERR_OOR              <= err_out_d;
      TAPS_DONE            <= taps_out_d;
      DELAY_LINE_SEL       <= sel_d;
      DELAY_LINE_DIRECTION <= dir_d;
      DELAY_LINE_LOAD      <= load_d;
      DELAY_LINE_MOVE      <= move_d;
      HS_IO_CLK_PAUSE      <= pause_d;
    end
  end

endmodule
